// File: rtl/fsab_dma_write_controller_pkg.sv
// Shared FSAB bus definitions for the DMA write controller.
// Bus field widths, request mode encodings, the burst-length encoding
// helper, and vector typedefs used by the interface and the modules.
package fsab_dma_write_controller_pkg;

    localparam int FSAB_ADDR_HI = 30;
    localparam int FSAB_DATA_HI = 63;
    localparam int FSAB_REQ_HI  = 0;
    localparam int FSAB_DID_HI  = 3;
    localparam int FSAB_LEN_HI  = 3;
    localparam int FSAB_MASK_HI = (FSAB_DATA_HI + 1) / 8 - 1;

    localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
    localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

    typedef logic [FSAB_ADDR_HI:0] fsab_addr_t;
    typedef logic [FSAB_DATA_HI:0] fsab_data_t;
    typedef logic [FSAB_REQ_HI:0]  fsab_req_t;
    typedef logic [FSAB_DID_HI:0]  fsab_did_t;
    typedef logic [FSAB_LEN_HI:0]  fsab_len_t;
    typedef logic [FSAB_MASK_HI:0] fsab_mask_t;

    // Length field carries the beat count directly.
    function automatic fsab_len_t fsab_len(input int beats);
        return fsab_len_t'(beats);
    endfunction

endpackage

// File: rtl/fsab_dma_write_controller_if.sv
// FSAB request-side port of the DMA write controller (dmac__ arbiter slot).
//   master : controller side, drives the request beat, receives credit returns
//   slave  : arbiter side
interface fsab_dma_write_controller_if;
    import fsab_dma_write_controller_pkg::*;

    logic       dmac__fsabo_valid;
    fsab_req_t  dmac__fsabo_mode;
    fsab_did_t  dmac__fsabo_did;
    fsab_did_t  dmac__fsabo_subdid;
    fsab_addr_t dmac__fsabo_addr;
    fsab_len_t  dmac__fsabo_len;
    fsab_data_t dmac__fsabo_data;
    fsab_mask_t dmac__fsabo_mask;
    logic       dmac__fsabo_credit;

    modport master (
        output dmac__fsabo_valid, dmac__fsabo_mode, dmac__fsabo_did,
               dmac__fsabo_subdid, dmac__fsabo_addr, dmac__fsabo_len,
               dmac__fsabo_data, dmac__fsabo_mask,
        input  dmac__fsabo_credit
    );

    modport slave (
        input  dmac__fsabo_valid, dmac__fsabo_mode, dmac__fsabo_did,
               dmac__fsabo_subdid, dmac__fsabo_addr, dmac__fsabo_len,
               dmac__fsabo_data, dmac__fsabo_mask,
        output dmac__fsabo_credit
    );

endinterface

// File: rtl/fsab_dma_write_controller_fifo.sv
// dma_write_fifo: synchronous FIFO buffering stream words for the DMA writer.
// Ports: clk, rst_b (sync active-low, empties the FIFO), push_i/wdata_i,
//        pop_i/rdata_o (head word, combinational), count_o, full_o, empty_o.
// Push while full and pop while empty are ignored.
module dma_write_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fsab_dma_write_controller.sv
// fsab_dma_write_controller: streaming DMA writer. Buffers a valid/ready word
// stream and writes it into [start_addr, end_addr) as fixed BURST_LEN-beat
// FSAB write bursts, gated by FSAB credits.
// Ports: clk, rst_b (sync active-low), go (start pulse, honoured when idle),
//        start_addr/end_addr (window), in_valid/in_data/in_ready (stream),
//        busy/done (status), dmac (FSAB request port, master modport).
// Build option: DMA_WRITE_RING_EN makes the window a ring: on reaching
// end_addr the address reloads start_addr, done pulses for one cycle and the
// transfer keeps running until reset.
//
// state  | meaning
// IDLE   | waiting for go
// WAIT   | waiting for a full burst of data and enough credits
// BURST  | issuing BURST_LEN consecutive write beats
// DONE   | window written, done held until next go
module fsab_dma_write_controller
    import fsab_dma_write_controller_pkg::*;
#(
    parameter int        BURST_LEN  = 8,
    parameter int        FIFO_DEPTH = 16,
    parameter int        CREDITS    = 8,
    parameter fsab_did_t DID        = 4'h3
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       go,
    input  fsab_addr_t start_addr,
    input  fsab_addr_t end_addr,
    input  logic       in_valid,
    input  fsab_data_t in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    fsab_dma_write_controller_if.master dmac
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int BPB         = (FSAB_DATA_HI + 1) / 8;
    localparam int BURST_BYTES = BURST_LEN * BPB;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W      = $clog2(CREDITS + 1);
    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [1:0]        state_q, state_d;
    fsab_addr_t        cur_addr_q, cur_addr_d;
    fsab_addr_t        end_addr_q, end_addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              done_q, done_d;
`ifdef DMA_WRITE_RING_EN
    fsab_addr_t        start_addr_q, start_addr_d;
`endif

    logic              beat_valid;
    logic              last_beat;
    fsab_addr_t        next_addr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    fsab_data_t        fifo_head;

    assign beat_valid = (state_q == ST_BURST);
    assign last_beat  = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign next_addr  = cur_addr_q + fsab_addr_t'(BURST_BYTES);

    // Readiness comes from the registered count, so a pop in the same cycle
    // never opens a slot early.
    assign in_ready = !fifo_full && (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign busy     = (state_q == ST_WAIT) || (state_q == ST_BURST);
    assign done     = done_q;

    dma_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FSAB_DATA_HI + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .push_i  (in_valid && in_ready),
        .wdata_i (in_data),
        .pop_i   (beat_valid && !fifo_empty),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Request fields are forced to zero off-beat so the arbiter can OR ports.
    assign dmac.dmac__fsabo_valid  = beat_valid;
    assign dmac.dmac__fsabo_mode   = beat_valid ? FSAB_WRITE : '0;
    assign dmac.dmac__fsabo_did    = beat_valid ? DID : '0;
    assign dmac.dmac__fsabo_subdid = '0;
    assign dmac.dmac__fsabo_addr   = beat_valid ? cur_addr_q : '0;
    assign dmac.dmac__fsabo_len    = beat_valid ? fsab_len(BURST_LEN) : '0;
    assign dmac.dmac__fsabo_data   = beat_valid ? fifo_head : '0;
    assign dmac.dmac__fsabo_mask   = beat_valid ? '1 : '0;

    always_comb begin
        credits_d = credits_q;
        case ({beat_valid, dmac.dmac__fsabo_credit})
            2'b10:   credits_d = credits_q - CRED_W'(1);
            2'b01:   credits_d = credits_q + CRED_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        beat_d     = beat_q;
`ifdef DMA_WRITE_RING_EN
        start_addr_d = start_addr_q;
        done_d       = (state_q == ST_DONE);
`else
        done_d       = done_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    cur_addr_d = start_addr;
                    end_addr_d = end_addr;
`ifdef DMA_WRITE_RING_EN
                    start_addr_d = start_addr;
`endif
                    if (start_addr == end_addr) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        done_d  = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                // Data and credits for the whole burst are reserved up front,
                // so the burst itself never stalls.
                if ((fifo_count >= CNT_W'(BURST_LEN)) &&
                    (credits_q >= CRED_W'(BURST_LEN))) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                beat_d = beat_q + BEAT_W'(1);
                if (last_beat) begin
                    if (next_addr == end_addr_q) begin
`ifdef DMA_WRITE_RING_EN
                        cur_addr_d = start_addr_q;
                        state_d    = ST_WAIT;
`else
                        cur_addr_d = next_addr;
                        state_d    = ST_DONE;
`endif
                        done_d     = 1'b1;
                    end else begin
                        cur_addr_d = next_addr;
                        state_d    = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            beat_q     <= '0;
            credits_q  <= CRED_W'(CREDITS);
            done_q     <= 1'b0;
`ifdef DMA_WRITE_RING_EN
            start_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            beat_q     <= beat_d;
            credits_q  <= credits_d;
            done_q     <= done_d;
`ifdef DMA_WRITE_RING_EN
            start_addr_q <= start_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_fsab_dma_write_controller.sv
module tb_fsab_dma_write_controller;
    import fsab_dma_write_controller_pkg::*;

    logic       clk;
    logic       rst_b;
    logic       go;
    fsab_addr_t start_addr;
    fsab_addr_t end_addr;
    logic       in_valid;
    fsab_data_t in_data;
    logic       in_ready;
    logic       busy;
    logic       done;

    fsab_dma_write_controller_if bus ();

    fsab_dma_write_controller dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .go         (go),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .dmac       (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // arbiter model state
    int  pend      = 0;
    bit  cred_en   = 0;
    int  exp_cred  = 8;
    bit  chk_en    = 0;
    int  done_cnt  = 0;
    int  simul_cnt = 0;
    logic [30:0] q_addr [$];
    logic [63:0] q_data [$];

    typedef struct {
        logic [30:0] s;
        logic [30:0] e;
        int          nb;
        logic [63:0] base;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Beat capture, field checks, credit model, idle-zero checks.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                exp_cred = 8;
            end else if (chk_en) begin
                check("credit_count", 128'(dut.credits_q), 128'(exp_cred));
                if (done) done_cnt++;
                if (bus.dmac__fsabo_valid) begin
                    q_addr.push_back(bus.dmac__fsabo_addr);
                    q_data.push_back(bus.dmac__fsabo_data);
                    check("beat_fields",
                          {bus.dmac__fsabo_mode, bus.dmac__fsabo_did, bus.dmac__fsabo_subdid,
                           bus.dmac__fsabo_len, bus.dmac__fsabo_mask},
                          {1'b1, 4'h3, 4'h0, 4'd8, 8'hFF});
                    pend++;
                    if (bus.dmac__fsabo_credit) simul_cnt++;
                    else exp_cred--;
                end else begin
                    check("idle_zero",
                          {bus.dmac__fsabo_mode, bus.dmac__fsabo_did, bus.dmac__fsabo_subdid,
                           bus.dmac__fsabo_addr, bus.dmac__fsabo_len, bus.dmac__fsabo_data,
                           bus.dmac__fsabo_mask}, 128'd0);
                    if (bus.dmac__fsabo_credit) exp_cred++;
                end
            end
        end
    end

    // Credit return: one pulse per consumed beat while enabled.
    initial begin
        bus.dmac__fsabo_credit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cred_en && pend > 0) begin
                bus.dmac__fsabo_credit = 1'b1;
                pend--;
            end else begin
                bus.dmac__fsabo_credit = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_go(input logic [30:0] s, input logic [30:0] e);
        start_addr = s;
        end_addr   = e;
        go         = 1'b1;
        step(1);
        go         = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [63:0] base, input int budget, output int acc);
        int  i   = 0;
        int  cyc = 0;
        bit  ok;
        in_valid = 1'b1;
        while (i < n && cyc < budget) begin
            in_data = base + 64'(i);
            @(negedge clk);
            ok = in_ready;
            step(1);
            if (ok) i++;
            cyc++;
        end
        in_valid = 1'b0;
        acc = i;
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        while (!done && cyc < budget) begin
            step(1);
            cyc++;
        end
        check("done_reached", 128'(done), 128'd1);
    endtask

    task automatic drain_credits();
        int cyc = 0;
        while ((pend != 0 || bus.dmac__fsabo_credit) && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("credits_drained", 128'(pend), 128'd0);
    endtask

    task automatic check_beats(input string nm, input int n, input logic [30:0] s,
                               input int ring_bursts, input logic [63:0] base);
        logic [30:0] ea;
        check({nm, "_beat_count"}, 128'(q_addr.size()), 128'(n));
        if (q_addr.size() == n) begin
            for (int j = 0; j < n; j++) begin
                if (ring_bursts > 0) ea = s + 31'(((j / 8) % ring_bursts) * 64);
                else                 ea = s + 31'((j / 8) * 64);
                check({nm, "_addr"}, 128'(q_addr[j]), 128'(ea));
                check({nm, "_data"}, 128'(q_data[j]), 128'(base + 64'(j)));
            end
        end
    endtask

    task automatic do_reset();
        rst_b   = 1'b0;
        cred_en = 1'b0;
        pend    = 0;
        step(2);
        rst_b = 1'b1;
    endtask

    initial begin
        vec_t vecs [4];
        int   acc;
        int   cyc;

        vecs[0] = '{31'h1000,     31'h1040, 1, 64'h0,                  1'b1, 1'b0};
        vecs[1] = '{31'h2000,     31'h20C0, 3, 64'h100,                1'b1, 1'b0};
        vecs[2] = '{31'h3000,     31'h3000, 0, 64'h0,                  1'b1, 1'b0};
        vecs[3] = '{31'h7FFFFFC0, 31'h40,   2, 64'hA5A5_0000_0000_0000, 1'b1, 1'b0};

        rst_b = 1'b0; go = 1'b0; start_addr = '0; end_addr = '0;
        in_valid = 1'b0; in_data = '0;
        step(3);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_valid", 128'(bus.dmac__fsabo_valid), 128'd0);
        check("rst_credits", 128'(dut.credits_q), 128'd8);
        rst_b  = 1'b1;
        chk_en = 1'b1;
        step(1);
        check("idle_in_ready", 128'(in_ready), 128'd0);

`ifndef DMA_WRITE_RING_EN
        // table-driven windows
        cred_en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            q_addr.delete();
            q_data.delete();
            pulse_go(vecs[v].s, vecs[v].e);
            if (vecs[v].nb == 0) begin
                check("empty_window_done", 128'(done), 128'd1);
                check("empty_window_in_ready", 128'(in_ready), 128'd0);
            end else begin
                check("go_busy", 128'(busy), 128'd1);
                check("go_done_clear", 128'(done), 128'd0);
                push_words(vecs[v].nb * 8, vecs[v].base, 400, acc);
                check("vec_accepted", 128'(acc), 128'(vecs[v].nb * 8));
                wait_done(100);
            end
            check("vec_done", 128'(done), 128'(vecs[v].exp_done));
            check("vec_busy", 128'(busy), 128'(vecs[v].exp_busy));
            check_beats("vec", vecs[v].nb * 8, vecs[v].s, 0, vecs[v].base);
        end
        drain_credits();

        // credit starvation
        cred_en = 1'b0;
        q_addr.delete(); q_data.delete();
        pulse_go(31'h1000, 31'h1080);
        push_words(16, 64'h200, 100, acc);
        check("starve_accepted", 128'(acc), 128'd16);
        step(40);
        check("starve_beats", 128'(q_addr.size()), 128'd8);
        check("starve_busy", 128'(busy), 128'd1);
        check("starve_done", 128'(done), 128'd0);
        cred_en = 1'b1;
        wait_done(100);
        check_beats("starve", 16, 31'h1000, 0, 64'h200);
        drain_credits();

        // backpressure with no credits
        cred_en = 1'b0;
        q_addr.delete(); q_data.delete();
        pulse_go(31'h4000, 31'h4100);
        push_words(8, 64'h300, 50, acc);
        step(20);
        check("bp_first_burst", 128'(q_addr.size()), 128'd8);
        push_words(20, 64'h308, 40, acc);
        check("bp_accepted_full", 128'(acc), 128'd16);
        check("bp_in_ready_low", 128'(in_ready), 128'd0);
        cred_en = 1'b1;
        push_words(8, 64'h318, 200, acc);
        check("bp_rest_accepted", 128'(acc), 128'd8);
        wait_done(100);
        check_beats("bp", 32, 31'h4000, 0, 64'h300);
        drain_credits();
        step(2);
        check("final_credits", 128'(dut.credits_q), 128'd8);
        check("simul_seen", 128'(simul_cnt > 0), 128'd1);
`else
        // ring buffer
        cred_en  = 1'b1;
        done_cnt = 0;
        q_addr.delete(); q_data.delete();
        pulse_go(31'h1000, 31'h1080);
        push_words(32, 64'h500, 300, acc);
        check("ring_accepted", 128'(acc), 128'd32);
        cyc = 0;
        while (q_addr.size() < 32 && cyc < 200) begin
            step(1);
            cyc++;
        end
        step(4);
        check_beats("ring", 32, 31'h1000, 2, 64'h500);
        check("ring_done_pulses", 128'(done_cnt), 128'd2);
        check("ring_busy", 128'(busy), 128'd1);
        check("ring_done_low", 128'(done), 128'd0);
        do_reset();
`endif

        // reset on beat 3 of a burst
        drain_credits();
        cred_en = 1'b1;
        q_addr.delete(); q_data.delete();
        pulse_go(31'h5000, 31'h5040);
        push_words(8, 64'h600, 50, acc);
        cyc = 0;
        while (!bus.dmac__fsabo_valid && cyc < 30) begin
            step(1);
            cyc++;
        end
        check("rb_burst_started", 128'(bus.dmac__fsabo_valid), 128'd1);
        step(3);
        rst_b   = 1'b0;
        cred_en = 1'b0;
        pend    = 0;
        step(1);
        check("rb_valid", 128'(bus.dmac__fsabo_valid), 128'd0);
        check("rb_outputs_zero",
              {bus.dmac__fsabo_mode, bus.dmac__fsabo_did, bus.dmac__fsabo_addr,
               bus.dmac__fsabo_len, bus.dmac__fsabo_data, bus.dmac__fsabo_mask}, 128'd0);
        check("rb_busy", 128'(busy), 128'd0);
        check("rb_done", 128'(done), 128'd0);
        check("rb_in_ready", 128'(in_ready), 128'd0);
        check("rb_credits", 128'(dut.credits_q), 128'd8);
        check("rb_fifo_empty", 128'(dut.u_fifo.count_q), 128'd0);
        rst_b = 1'b1;
        step(1);

`ifndef DMA_WRITE_RING_EN
        cred_en = 1'b1;
        q_addr.delete(); q_data.delete();
        pulse_go(31'h6000, 31'h6040);
        push_words(8, 64'h700, 50, acc);
        wait_done(100);
        check_beats("after_rst", 8, 31'h6000, 0, 64'h700);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
